// File: rtl/imem_loader.sv
// Instruction memory loader: zero-fills the instruction memory, then streams
// in a program through a valid/ready handshake, runs the CPU for a fixed
// number of cycles and halts.
//
// state | meaning
// ------+----------------------------------------------------------------
// CLEAR | writing zero to every word address, ascending, one per cycle
// LOAD  | accepting program words; ready low here means the final write is on the bus
// RUN   | cpu_start_o high, cycle_cnt_o counting up from 0
// DONE  | halted after RUN_CYCLES cycles, waiting for restart_i or reset
module imem_loader #(
  parameter int DEPTH      = 256,
  parameter int AW         = 8,
  parameter int RUN_CYCLES = 30
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          restart_i,
  input  logic          load_valid_i,
  input  logic [31:0]   load_data_i,
  input  logic          load_last_i,
  output logic          load_ready_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_data_o,
  output logic          cpu_start_o,
  output logic [AW:0]   words_loaded_o,
  output logic [15:0]   cycle_cnt_o,
  output logic          done_o
);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN, DONE} state_t;

  localparam logic [AW:0]   CLR_END  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [15:0]   RUN_LAST = 16'(RUN_CYCLES - 1);
  localparam logic [15:0]   RUN_END  = 16'(RUN_CYCLES);

  state_t        state_q, state_d;
  logic [AW:0]   clr_q, clr_d;      // number of zero-fill writes already issued
  logic [AW-1:0] idx_q, idx_d;      // address for the next accepted program word
  logic          ready_d, we_d, start_d, done_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   data_d;
  logic [AW:0]   words_d;
  logic [15:0]   cnt_d;
  logic          accept;

  // load_ready_o is only ever high in LOAD, so this is the handshake itself.
  assign accept = (state_q == LOAD) && load_ready_o && load_valid_i;

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    idx_d   = idx_q;
    ready_d = load_ready_o;
    we_d    = 1'b0;
    addr_d  = imem_addr_o;
    data_d  = imem_data_o;
    start_d = cpu_start_o;
    done_d  = done_o;
    words_d = words_loaded_o;
    cnt_d   = cycle_cnt_o;
    if (restart_i) begin
      // Restart wins over everything; the zero write to address 0 is issued
      // right away so a coincident acceptance never reaches the memory.
      state_d = CLEAR;
      we_d    = 1'b1;
      addr_d  = '0;
      data_d  = '0;
      clr_d   = (AW+1)'(1);
      idx_d   = '0;
      ready_d = 1'b0;
      start_d = 1'b0;
      done_d  = 1'b0;
      words_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_q == CLR_END) begin
            state_d = LOAD;
            ready_d = 1'b1;
            idx_d   = '0;
          end else begin
            we_d   = 1'b1;
            addr_d = clr_q[AW-1:0];
            data_d = '0;
            clr_d  = clr_q + 1'b1;
          end
        end
        LOAD: begin
          if (!load_ready_o) begin
            state_d = RUN;
            start_d = 1'b1;
            cnt_d   = '0;
          end else if (accept) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            data_d  = load_data_i;
            idx_d   = idx_q + 1'b1;
            words_d = words_loaded_o + 1'b1;
            if (load_last_i || (idx_q == LAST_IDX)) ready_d = 1'b0;
          end
        end
        RUN: begin
          if (cycle_cnt_o == RUN_LAST) begin
            state_d = DONE;
            start_d = 1'b0;
            done_d  = 1'b1;
            cnt_d   = RUN_END;
          end else begin
            cnt_d = cycle_cnt_o + 16'd1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  // State and output registers, all cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= CLEAR;
      clr_q          <= '0;
      idx_q          <= '0;
      load_ready_o   <= 1'b0;
      imem_we_o      <= 1'b0;
      imem_addr_o    <= '0;
      imem_data_o    <= '0;
      cpu_start_o    <= 1'b0;
      done_o         <= 1'b0;
      words_loaded_o <= '0;
      cycle_cnt_o    <= '0;
    end else begin
      state_q        <= state_d;
      clr_q          <= clr_d;
      idx_q          <= idx_d;
      load_ready_o   <= ready_d;
      imem_we_o      <= we_d;
      imem_addr_o    <= addr_d;
      imem_data_o    <= data_d;
      cpu_start_o    <= start_d;
      done_o         <= done_d;
      words_loaded_o <= words_d;
      cycle_cnt_o    <= cnt_d;
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256: instruction memory depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter AW, default 8: word-address width, equal to log2(DEPTH).
REQ-003 The block SHALL have parameter RUN_CYCLES, default 30: number of CPU clock cycles to run before halting.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk_i  input  1  clock, all state on the rising edge.
REQ-005 The block SHALL have rst_i  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have restart_i  input  1  one-cycle pulse that restarts the sequence from CLEAR.
REQ-007 The block SHALL have load_valid_i  input  1  program word valid.
REQ-008 The block SHALL have load_data_i  input  32  program word, little-endian RISC-V instruction.
REQ-009 The block SHALL have load_last_i  input  1  marks the final program word; qualified by load_valid_i.
REQ-010 The block SHALL have load_ready_o  output  1  word accepted when load_valid_i and load_ready_o are both high.
REQ-011 The block SHALL have imem_we_o  output  1  instruction memory write strobe.
REQ-012 The block SHALL have imem_addr_o  output  AW  instruction memory word address.
REQ-013 The block SHALL have imem_data_o  output  32  instruction memory write data.
REQ-014 The block SHALL have cpu_start_o  output  1  CPU start/run enable, connected to CPU start_i.
REQ-015 The block SHALL have words_loaded_o  output  AW+1  count of program words accepted.
REQ-016 The block SHALL have cycle_cnt_o  output  16  CPU cycles elapsed in RUN.
REQ-017 The block SHALL have done_o  output  1  high while halted after RUN_CYCLES.

Function
REQ-018 The FSM SHALL have states CLEAR, LOAD, RUN and DONE, and SHALL enter CLEAR on reset.
REQ-019 In CLEAR, the block SHALL write 32'b0 to addresses 0..DEPTH-1, one per cycle in ascending order, with imem_we_o=1, then enter LOAD; CLEAR lasts exactly DEPTH cycles.
REQ-020 load_ready_o SHALL be 1 only in LOAD and SHALL be a registered output.
REQ-021 A word accepted in cycle N SHALL appear on imem_we_o=1, imem_addr_o=word index and imem_data_o=load_data_i in cycle N+1; imem_we_o SHALL be 0 in cycles with no acceptance.
REQ-022 Word index SHALL start at 0 in LOAD and increment by 1 per accepted word; words_loaded_o SHALL increment in the same cycle as the write.
REQ-023 Acceptance with load_last_i=1, or acceptance at index DEPTH-1, SHALL end LOAD: load_ready_o SHALL drop the next cycle and the FSM SHALL enter RUN after the final write cycle.
REQ-024 Words presented after LOAD ends SHALL never be accepted or written.
REQ-025 In RUN, cpu_start_o SHALL be 1 and cycle_cnt_o SHALL increment by 1 per cycle starting from 0.
REQ-026 When cycle_cnt_o reaches RUN_CYCLES-1, the FSM SHALL enter DONE on the next edge: cpu_start_o=0, done_o=1, and cycle_cnt_o frozen at RUN_CYCLES.
REQ-027 cpu_start_o SHALL be 0 in CLEAR, LOAD and DONE.
REQ-028 DONE SHALL be held until restart_i or reset.
REQ-029 restart_i in any state SHALL, on the next edge, enter CLEAR at address 0 and zero words_loaded_o, cycle_cnt_o and done_o; restart_i SHALL take priority over every other transition in the same cycle.
REQ-030 An acceptance coinciding with restart_i SHALL be discarded, and no write for it SHALL occur.
REQ-031 An empty program, with load_last_i never asserted, SHALL keep the FSM in LOAD indefinitely with cpu_start_o=0.

Reset
REQ-032 While rst_i=1, all outputs SHALL be forced immediately and asynchronously: load_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_data_o=0, cpu_start_o=0, words_loaded_o=0, cycle_cnt_o=0, done_o=0.
REQ-033 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation, and a partial program SHALL NOT be resumed.
REQ-034 On the first rising edge after rst_i falls, the block SHALL begin CLEAR with a write to address 0.

Verification
REQ-035 The bench SHALL cover: reset release -> 256 consecutive writes of 0 at addresses 0..255, then load_ready_o=1 in cycle 257.
REQ-036 The bench SHALL cover: 3 words 0x00000013, 0x00500093, 0x00A00113 with the last flagged, valid held high -> writes at addresses 0, 1, 2, each one cycle after acceptance, words_loaded_o=3, then cpu_start_o=1.
REQ-037 The bench SHALL cover: RUN with RUN_CYCLES=30 -> cpu_start_o high for exactly 30 cycles, then done_o=1, cycle_cnt_o=30, cpu_start_o=0.
REQ-038 The bench SHALL cover: 300 words streamed with no last flag -> exactly 256 accepted, the final write at address 255, words_loaded_o=256, load_ready_o=0 afterwards.
REQ-039 The bench SHALL cover: valid toggling every other cycle -> only handshaken words are written, addresses contiguous with no gaps.
REQ-040 The bench SHALL cover: restart_i pulsed at cycle_cnt_o=10, and separately coinciding with an acceptance -> CLEAR restarts at address 0, counters are zero, and the coincident word is never written.
